yas_router_nch: RTL and testbench
=================================

Name: yas_router_nch

Overview:
- Parametrised next-generation router core: one byte-serial req/ack input, NUM_CH output channels.
- Each channel has an internal store-and-forward packet FIFO and its own req/ack output.
- Generalises the fixed 3-channel, 8-bit router in channel count, width and depth.
- Adds what the 3-channel router lacks: address-miss drop, optional checksum verification, rollback of bad packets, and a whole-packet space check.
- Top-level routing core: fed by the link input, drives NUM_CH downstream consumers, configured through the config port.

Parameters:
- DATA_WIDTH, 8: byte width.
- ADDR_W, 2: header address field width.
- NUM_CH, 3: output channel count (1..2^ADDR_W).
- PTR_W, 6: FIFO depth = 2^PTR_W words. Must satisfy 2^PTR_W >= 2^(DATA_WIDTH-ADDR_W).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  DATA_WIDTH  input byte.
- data_in_req  in  1  source holds high while data_in is valid.
- data_in_ack  out  1  one-cycle pulse: byte consumed this cycle.
- data_out  out  NUM_CH*DATA_WIDTH  per-channel head word; channel i occupies slice i.
- data_out_req  out  NUM_CH  channel i has a committed word.
- data_out_ack  in  NUM_CH  consumer pops channel i.
- config_addr  in  clog2(NUM_CH+1)  register index.
- config_data  in  ADDR_W  register write data.
- config_en  in  1  write strobe.
- pkt_drop  out  1  one-cycle pulse: packet discarded.

Behaviour:
- Reset values (asynchronous on rst_n low): all outputs 0, all pointers 0, FSM = HDR, all ch_addr[i] = i, crc_en = 0. A partially received packet is lost and nothing is committed.
- Config: on config_en, index < NUM_CH writes ch_addr[index]; index == NUM_CH writes crc_en from config_data[0]; larger indices are ignored. ch_addr and crc_en are sampled at header acceptance and held for the rest of that packet.
- Packet format: header = {len[DATA_WIDTH-ADDR_W-1:0], addr[ADDR_W-1:0]}, then len payload bytes, then one checksum byte if crc_en. Checksum = XOR of header and all payload bytes.
- Input handshake: data_in_ack = data_in_req & accept_condition, combinational with registered qualifiers. The source advances data in the cycle after ack. No ack while req is low.
- Routing: target = lowest i with ch_addr[i] == addr. No match -> DISCARD.
- Space check: free = 2^PTR_W - (wr_spec - rd). The header is not acked (stall) until free >= len+1. Other channels do not progress meanwhile (single input).
- FSM HDR: on ack, write the header at wr_spec. Next state:
  - PAYLOAD if len > 0.
  - else CHECK if crc_en.
  - else commit and stay in HDR.
- FSM PAYLOAD: write each byte and decrement the counter. After the last byte: CHECK if crc_en, else commit and go to HDR.
- FSM CHECK: ack the checksum byte; it is not stored. On match, commit. On mismatch, wr_spec <= wr_commit (rollback) and pulse pkt_drop. Then go to HDR.
- FSM DISCARD: ack and drop len payload bytes plus the checksum byte if crc_en, then pulse pkt_drop and return to HDR. len = 0 without crc_en pulses pkt_drop in the cycle after the header.
- Commit: wr_commit <= wr_spec at the clock edge of the last-byte ack. data_out_req rises the next cycle.
- Output side:
  - data_out_req[i] = (wr_commit != rd); only committed words are visible, partial packets never are.
  - data_out slice i = mem[rd], combinational from registered rd.
  - Pop when req & ack; rd increments and data updates the next cycle.
  - Ack while req is low is ignored.
- Pointers are PTR_W+1 bits and wrap naturally; full/empty are distinguished by the MSB.
- A simultaneous pop and write on the same channel is legal; free space counts the pop one cycle late (conservative).

Decomposition:
- Shared package yas_router_pkg: state encoding (HDR, PAYLOAD, CHECK, DISCARD), header field slicing functions, clog2 constant function.
- Sub-module pkt_fifo: speculative/commit/rollback FIFO (push, commit, rollback, pop, free, empty), instantiated NUM_CH times in a generate loop.

Test Plan:
- Defaults, crc_en=0: send header 0x0D (len 3, addr 1) plus 0xAA 0xBB 0xCC -> channel 1 req rises the cycle after the 4th ack; pops yield 0x0D, 0xAA, 0xBB, 0xCC; channels 0 and 2 stay idle.
- crc_en=1 (write index 3, data 1): packet 0x08 (len 2, addr 0), 0x11, 0x22, checksum 0x3B -> delivered on ch0. Same packet with checksum 0x3A -> no req on ch0, pkt_drop pulses once, pointers restored.
- Write ch_addr[2]=3, then header addr 3 -> routed to ch2. Header addr 2 with no match -> all bytes acked, pkt_drop pulses, nothing stored.
- Fill ch0 with a 63-byte packet, consumer idle, then send a len-5 header to ch0 -> header not acked. Pop 6 words -> header acked and the packet completes.
- Assert rst_n low mid-payload -> all req and ack drop asynchronously. After release, a fresh packet routes correctly and no stale data appears.
- Zero-length packet with crc_en=1: header 0x02 then checksum 0x02 -> single-word packet delivered on ch2.

Source files
------------

// File: rtl/yas_router_pkg.sv
// rtl/yas_router_pkg.sv - shared types and helpers for the yas_router_nch core
// Purpose: FSM state encoding, header field slicing, constant clog2.
// Ports: none (package).
package yas_router_pkg;

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2,
    ST_DISCARD = 2'd3
  } state_e;

  // Ceiling log2, never below 1 so it can size a one-bit field.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Header = {len, addr}; the caller truncates the result to its field width.
  function automatic logic [31:0] hdr_addr(input logic [31:0] hdr, input int addr_w);
    return hdr & ((32'd1 << addr_w) - 32'd1);
  endfunction

  function automatic logic [31:0] hdr_len(input logic [31:0] hdr, input int addr_w);
    return hdr >> addr_w;
  endfunction

endpackage

// File: rtl/yas_router_nch_pkt_fifo.sv
// rtl/yas_router_nch_pkt_fifo.sv - speculative-write packet FIFO with commit and rollback
// Purpose: store-and-forward buffer; only committed words are visible to the reader.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push_i/push_data_i speculative write at wr_spec
//   commit_i          publish everything written so far (including a push this cycle)
//   rollback_i        discard uncommitted words (wr_spec <= wr_commit)
//   pop_i             advance read pointer (ignored when empty)
//   rd_data_o         word at the read pointer
//   free_o            words free relative to the speculative write pointer
//   empty_o           no committed word available
module pkt_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  commit_i,
  input  logic                  rollback_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [PTR_W:0]        free_o,
  output logic                  empty_o
);

  localparam int             DEPTH = 1 << PTR_W;
  localparam logic [PTR_W:0] ONE   = (PTR_W+1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]        wr_spec_q, wr_spec_d;
  logic [PTR_W:0]        wr_commit_q, wr_commit_d;
  logic [PTR_W:0]        rd_q, rd_d;

  assign empty_o   = (wr_commit_q == rd_q);
  assign rd_data_o = mem_q[rd_q[PTR_W-1:0]];
  // Uses the registered read pointer, so a pop is credited one cycle late.
  assign free_o    = (PTR_W+1)'(DEPTH) - (wr_spec_q - rd_q);

  always_comb begin
    wr_spec_d   = wr_spec_q;
    wr_commit_d = wr_commit_q;
    rd_d        = rd_q;
    if (rollback_i) begin
      wr_spec_d = wr_commit_q;
    end else begin
      if (push_i)   wr_spec_d   = wr_spec_q + ONE;
      if (commit_i) wr_commit_d = wr_spec_d;
    end
    if (pop_i && !empty_o) rd_d = rd_q + ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_spec_q   <= '0;
      wr_commit_q <= '0;
      rd_q        <= '0;
    end else begin
      wr_spec_q   <= wr_spec_d;
      wr_commit_q <= wr_commit_d;
      rd_q        <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_spec_q[PTR_W-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/yas_router_nch.sv
// rtl/yas_router_nch.sv - byte-serial packet router with NUM_CH store-and-forward outputs
// Purpose: parse {len,addr} headers, route to the lowest matching channel, optionally
//   verify an XOR checksum, roll back bad packets, drop unrouted ones.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   data_in/data_in_req/_ack    input byte stream (ack is a one-cycle consume pulse)
//   data_out/data_out_req/_ack  per-channel head word, committed-data flag, pop
//   config_addr/_data/_en       register writes: ch_addr[0..NUM_CH-1], crc_en at NUM_CH
//   pkt_drop                    one-cycle pulse when a packet is discarded
module yas_router_nch
  import yas_router_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 2,
  parameter int NUM_CH     = 3,
  parameter int PTR_W      = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic                           data_in_req,
  output logic                           data_in_ack,
  output logic [NUM_CH*DATA_WIDTH-1:0]   data_out,
  output logic [NUM_CH-1:0]              data_out_req,
  input  logic [NUM_CH-1:0]              data_out_ack,
  input  logic [clog2(NUM_CH+1)-1:0]     config_addr,
  input  logic [ADDR_W-1:0]              config_data,
  input  logic                           config_en,
  output logic                           pkt_drop
);

  localparam int LEN_W = DATA_WIDTH - ADDR_W;
  localparam int CH_W  = clog2(NUM_CH);
  localparam int CFG_W = clog2(NUM_CH+1);
  localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     ch_addr_q [NUM_CH];
  logic                  crc_en_q;
  logic [CH_W-1:0]       tgt_q, tgt_d;
  logic                  crc_pkt_q, crc_pkt_d;
  logic [LEN_W:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic                  pkt_drop_q, pkt_drop_d;

  logic [LEN_W-1:0]      hdr_len_w;
  logic [ADDR_W-1:0]     hdr_addr_w;
  logic                  hit;
  logic [CH_W-1:0]       hit_idx;
  logic                  room;
  logic                  accept;
  logic                  push, commit, rollback;
  logic [CH_W-1:0]       wr_ch;

  logic [PTR_W:0]        free_v [NUM_CH];
  logic [DATA_WIDTH-1:0] rd_data_v [NUM_CH];
  logic [NUM_CH-1:0]     empty_v;

  assign hdr_len_w  = LEN_W'(hdr_len(32'(data_in), ADDR_W));
  assign hdr_addr_w = ADDR_W'(hdr_addr(32'(data_in), ADDR_W));

  // Descending scan so the lowest matching channel wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_addr_q[i] == hdr_addr_w) begin
        hit     = 1'b1;
        hit_idx = CH_W'(i);
      end
    end
  end

  // The whole packet (header + len payload words) must fit before the header is taken.
  assign room = (free_v[hit_idx] >= ((PTR_W+1)'(hdr_len_w) + (PTR_W+1)'(1)));

  always_comb begin
    accept = 1'b1;
    if (state_q == ST_HDR) accept = !hit || room;
  end

  assign data_in_ack = rst_n & data_in_req & accept;
  assign pkt_drop    = pkt_drop_q;

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    crc_pkt_d  = crc_pkt_q;
    cnt_d      = cnt_q;
    csum_d     = csum_q;
    pkt_drop_d = 1'b0;
    push       = 1'b0;
    commit     = 1'b0;
    rollback   = 1'b0;
    wr_ch      = tgt_q;
    case (state_q)
      ST_HDR: begin
        wr_ch = hit_idx;
        if (data_in_ack) begin
          tgt_d     = hit_idx;
          crc_pkt_d = crc_en_q;
          csum_d    = data_in;
          if (hit) begin
            push  = 1'b1;
            cnt_d = {1'b0, hdr_len_w};
            if (hdr_len_w != '0)  state_d = ST_PAYLOAD;
            else if (crc_en_q)    state_d = ST_CHECK;
            else                  commit  = 1'b1;
          end else begin
            // Unrouted: swallow payload plus checksum byte, if any.
            cnt_d = {1'b0, hdr_len_w} + (LEN_W+1)'(crc_en_q);
            if (hdr_len_w == '0 && !crc_en_q) pkt_drop_d = 1'b1;
            else                              state_d    = ST_DISCARD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (data_in_ack) begin
          push   = 1'b1;
          csum_d = csum_q ^ data_in;
          cnt_d  = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            if (crc_pkt_q) begin
              state_d = ST_CHECK;
            end else begin
              commit  = 1'b1;
              state_d = ST_HDR;
            end
          end
        end
      end
      ST_CHECK: begin
        if (data_in_ack) begin
          if (data_in == csum_q) begin
            commit = 1'b1;
          end else begin
            rollback   = 1'b1;
            pkt_drop_d = 1'b1;
          end
          state_d = ST_HDR;
        end
      end
      ST_DISCARD: begin
        if (data_in_ack) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            pkt_drop_d = 1'b1;
            state_d    = ST_HDR;
          end
        end
      end
      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HDR;
      tgt_q      <= '0;
      crc_pkt_q  <= 1'b0;
      cnt_q      <= '0;
      csum_q     <= '0;
      pkt_drop_q <= 1'b0;
      crc_en_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) ch_addr_q[i] <= ADDR_W'(i);
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      crc_pkt_q  <= crc_pkt_d;
      cnt_q      <= cnt_d;
      csum_q     <= csum_d;
      pkt_drop_q <= pkt_drop_d;
      if (config_en) begin
        if (config_addr < CFG_W'(NUM_CH))       ch_addr_q[config_addr] <= config_data;
        else if (config_addr == CFG_W'(NUM_CH)) crc_en_q <= config_data[0];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic sel;
    assign sel = (wr_ch == CH_W'(g));

    pkt_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .PTR_W      (PTR_W)
    ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push & sel),
      .push_data_i (data_in),
      .commit_i    (commit & sel),
      .rollback_i  (rollback & sel),
      .pop_i       (data_out_ack[g]),
      .rd_data_o   (rd_data_v[g]),
      .free_o      (free_v[g]),
      .empty_o     (empty_v[g])
    );

    assign data_out_req[g] = !empty_v[g];
    // Held at zero while nothing is committed, so idle outputs read 0.
    assign data_out[g*DATA_WIDTH +: DATA_WIDTH] = empty_v[g] ? '0 : rd_data_v[g];
  end

endmodule

// File: tb/tb_yas_router_nch.sv
// tb/tb_yas_router_nch.sv - scoreboard testbench for yas_router_nch
module tb_yas_router_nch;
  localparam int DW = 8, AW = 2, NCH = 3, PW = 6;
  typedef logic [7:0] bq_t[$];

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW-1:0]   data_in;
  logic            data_in_req;
  logic            data_in_ack;
  logic [NCH*DW-1:0] data_out;
  logic [NCH-1:0]  data_out_req;
  logic [NCH-1:0]  data_out_ack;
  logic [1:0]      config_addr;
  logic [AW-1:0]   config_data;
  logic            config_en;
  logic            pkt_drop;

  yas_router_nch #(.DATA_WIDTH(DW), .ADDR_W(AW), .NUM_CH(NCH), .PTR_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_in_req(data_in_req),
    .data_in_ack(data_in_ack), .data_out(data_out), .data_out_req(data_out_req),
    .data_out_ack(data_out_ack), .config_addr(config_addr), .config_data(config_data),
    .config_en(config_en), .pkt_drop(pkt_drop)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int drop_exp = 0, drop_seen = 0;
  int budget [NCH];
  int m_addr [NCH];
  bit m_crc;
  logic [7:0] exp_q [NCH][$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Consumer + scoreboard: pops whenever a channel presents a word and budget allows.
  initial begin
    logic [7:0] w, e;
    data_out_ack = '0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        data_out_ack[c] = 1'b0;
        if (rst_n && data_out_req[c] && budget[c] != 0 &&
            (budget[c] > 0 || $urandom_range(0, 3) != 0)) begin
          w = data_out[c*DW +: DW];
          n_cmp++;
          if (exp_q[c].size() == 0) begin
            n_err++;
            $display("FAIL ch%0d_unexpected_word: got 0x%02h expected none", c, w);
          end else begin
            e = exp_q[c].pop_front();
            if (w !== e) begin
              n_err++;
              $display("FAIL ch%0d_data: got 0x%02h expected 0x%02h", c, w, e);
            end
          end
          data_out_ack[c] = 1'b1;
          if (budget[c] > 0) budget[c]--;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (pkt_drop === 1'b1) drop_seen++;
    end
  end

  // Reference: route by lowest matching address, verify XOR checksum when enabled.
  task automatic model_pkt(input bq_t p);
    int len, addr, tgt;
    logic [7:0] x;
    bit ok;
    len  = int'(p[0]) >> AW;
    addr = int'(p[0]) % (1 << AW);
    tgt  = -1;
    for (int i = NCH - 1; i >= 0; i--) if (m_addr[i] == addr) tgt = i;
    x = 8'h00;
    for (int i = 0; i <= len; i++) x = x ^ p[i];
    ok = (tgt >= 0) && (!m_crc || p[len+1] == x);
    if (ok) for (int i = 0; i <= len; i++) exp_q[tgt].push_back(p[i]);
    else drop_exp++;
  endtask

  function automatic bq_t mk_pkt(input int len, input int addr, input bit crc, input bit corrupt);
    bq_t p;
    logic [7:0] x;
    p.push_back(8'((len << AW) | addr));
    for (int i = 0; i < len; i++) p.push_back(8'($urandom));
    x = 8'h00;
    foreach (p[i]) x = x ^ p[i];
    if (crc) p.push_back(corrupt ? (x ^ 8'h01) : x);
    return p;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int t;
    bit got;
    data_in = b;
    data_in_req = 1'b1;
    t = 0;
    got = 0;
    while (!got && t <= 3000) begin
      #1;
      if (data_in_ack) got = 1;
      else begin
        @(negedge clk);
        t++;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL ack_timeout: got no ack expected ack for 0x%02h", b);
    end
    @(negedge clk);
  endtask

  task automatic send_pkt(input bq_t p);
    foreach (p[i]) send_byte(p[i]);
    data_in_req = 1'b0;
    #1;
    chk("idle_ack", int'(data_in_ack), 0);
  endtask

  task automatic cfg(input int idx, input int val);
    config_addr = 2'(idx);
    config_data = AW'(val);
    config_en = 1'b1;
    @(negedge clk);
    config_en = 1'b0;
    if (idx < NCH) m_addr[idx] = val;
    else if (idx == NCH) m_crc = val[0];
  endtask

  task automatic drain(input string name);
    int t;
    bit busy;
    t = 0;
    busy = 1;
    while (busy && t < 5000) begin
      @(negedge clk);
      t++;
      busy = (data_out_req != '0);
      for (int c = 0; c < NCH; c++) if (exp_q[c].size() != 0) busy = 1;
    end
    chk({name, "_req_idle"}, int'(data_out_req), 0);
    for (int c = 0; c < NCH; c++) chk({name, "_queue_left"}, exp_q[c].size(), 0);
    chk({name, "_drops"}, drop_seen, drop_exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      exp_q[c].delete();
      m_addr[c] = c;
    end
    m_crc = 0;
  endtask

  initial begin
    bq_t p, p5;
    int acks;
    rst_n = 1'b0;
    data_in = '0;
    data_in_req = 1'b0;
    config_addr = '0;
    config_data = '0;
    config_en = 1'b0;
    model_reset();
    for (int c = 0; c < NCH; c++) budget[c] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_req", int'(data_out_req), 0);
    chk("rst_ack", int'(data_in_ack), 0);
    chk("rst_drop", int'(pkt_drop), 0);
    chk("rst_data", int'(data_out), 0);
    @(negedge clk);

    // Basic routing to channel 1 with commit latency check.
    p = '{8'h0D, 8'hAA, 8'hBB, 8'hCC};
    model_pkt(p);
    for (int i = 0; i < 3; i++) send_byte(p[i]);
    chk("t1_req_before_last", int'(data_out_req), 0);
    send_byte(p[3]);
    data_in_req = 1'b0;
    chk("t1_req_after_last", int'(data_out_req), 3'b010);
    chk("t1_head", int'(data_out[1*DW +: DW]), 8'h0D);
    for (int c = 0; c < NCH; c++) budget[c] = -1;
    drain("t1");

    // Checksum good, bad, then good again to show the rollback restored pointers.
    cfg(3, 1);
    p = '{8'h08, 8'h11, 8'h22, 8'h3B};
    model_pkt(p);
    send_pkt(p);
    drain("crc_good");
    p = '{8'h08, 8'h11, 8'h22, 8'h3A};
    model_pkt(p);
    send_pkt(p);
    drain("crc_bad");
    chk("crc_bad_drop_once", drop_seen, 1);
    p = mk_pkt(4, 0, 1, 0);
    model_pkt(p);
    send_pkt(p);
    drain("crc_after_rollback");

    // Remap ch2 to address 3; address 2 then misses.
    cfg(2, 3);
    p = mk_pkt(3, 3, 1, 0);
    model_pkt(p);
    send_pkt(p);
    p = mk_pkt(3, 2, 1, 0);
    model_pkt(p);
    send_pkt(p);
    drain("remap_miss");
    chk("miss_drops_total", drop_seen, 2);

    // Whole-packet space check on a full channel 0.
    cfg(3, 0);
    budget[0] = 0;
    p = mk_pkt(63, 0, 0, 0);
    model_pkt(p);
    send_pkt(p);
    p5 = mk_pkt(5, 0, 0, 0);
    model_pkt(p5);
    data_in = p5[0];
    data_in_req = 1'b1;
    acks = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (data_in_ack) acks++;
      @(negedge clk);
    end
    chk("stall_hdr_acks", acks, 0);
    chk("stall_ch0_req", int'(data_out_req[0]), 1);
    budget[0] = 6;
    send_pkt(p5);
    budget[0] = -1;
    drain("space");

    // Asynchronous reset in the middle of a payload.
    for (int c = 0; c < NCH; c++) budget[c] = 0;
    p = mk_pkt(2, 0, 0, 0);
    model_pkt(p);
    send_pkt(p);
    send_byte(8'h11);
    send_byte(8'h55);
    send_byte(8'h66);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ack", int'(data_in_ack), 0);
    chk("async_rst_req", int'(data_out_req), 0);
    data_in_req = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < NCH; c++) budget[c] = -1;
    p = mk_pkt(3, 1, 0, 0);
    model_pkt(p);
    send_pkt(p);
    drain("post_rst");

    // Zero-length packet with checksum.
    cfg(3, 1);
    p = '{8'h02, 8'h02};
    model_pkt(p);
    send_pkt(p);
    drain("zero_len_crc");

    // Zero-length miss without checksum drops right after the header.
    cfg(3, 0);
    cfg(0, 1);
    p = mk_pkt(0, 0, 0, 0);
    model_pkt(p);
    send_pkt(p);
    drain("zero_len_miss");

    // Randomised traffic with random remaps and checksum corruption.
    for (int n = 0; n < 40; n++) begin
      int len, addr;
      bit corrupt;
      if ($urandom_range(0, 3) == 0) cfg($urandom_range(0, NCH), $urandom_range(0, 3));
      len = $urandom_range(0, 12);
      addr = $urandom_range(0, 3);
      corrupt = ($urandom_range(0, 3) == 0);
      p = mk_pkt(len, addr, m_crc, corrupt);
      model_pkt(p);
      send_pkt(p);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
